// File: rtl/oqpsk_symbol_slicer.sv
// OQPSK receive slicer: sign-slices I/Q samples, strips the half-symbol offset and packs bits
// into AXI-Stream words. Define SYMBOL_ERROR_COUNT_EN to add the error_count output.
module oqpsk_symbol_slicer #(
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 16,
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_areset,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tvalid,
  output logic                              s00_axis_tready,
  input  logic                              s00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic                              m00_axis_tlast,
`ifdef SYMBOL_ERROR_COUNT_EN
  output logic [15:0]                       error_count,
`endif
  output logic                              frame_error
);

  localparam int unsigned W    = C_M00_AXIS_TDATA_WIDTH / 2;
  localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StFirst, StMiddle, StLast} state_e;

  state_e                              state_q, state_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [W-1:0]                        ibits_q, ibits_d;
  logic [W-1:0]                        qbits_q, qbits_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   out_data_q;
  logic                                out_valid_q;
  logic                                out_last_q;
  logic                                err_q, err_d;
  logic                                load;
  logic                                beat;
  logic                                i_bit, q_bit;
  logic                                unused_tdata;

  assign unused_tdata    = ^s00_axis_tdata;
  assign s00_axis_tready = ~(out_valid_q & ~m00_axis_tready);
  assign beat            = s00_axis_tvalid & s00_axis_tready;
  // Sign slice: zero on a data slot resolves to 1.
  assign i_bit           = ~s00_axis_tdata[31];
  assign q_bit           = ~s00_axis_tdata[15];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ibits_d = ibits_q;
    qbits_d = qbits_q;
    load    = 1'b0;
    err_d   = 1'b0;
    if (beat) begin
      unique case (state_q)
        StFirst: begin
          if (s00_axis_tlast) begin
            err_d   = 1'b1;
            ibits_d = '0;
            qbits_d = '0;
          end else begin
            ibits_d[0] = i_bit;
            cnt_d      = CntW'(1);
            state_d    = StMiddle;
          end
        end
        StMiddle: begin
          if (s00_axis_tlast) begin
            err_d   = 1'b1;
            ibits_d = '0;
            qbits_d = '0;
            cnt_d   = '0;
            state_d = StFirst;
          end else begin
            ibits_d[cnt_q]             = i_bit;
            qbits_d[cnt_q - CntW'(1)]  = q_bit;
            if (cnt_q == CntW'(W - 1)) begin
              state_d = StLast;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StLast: begin
          qbits_d[W-1] = q_bit;
          load         = 1'b1;
          cnt_d        = '0;
          state_d      = StFirst;
        end
        default: state_d = StFirst;
      endcase
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q     <= StFirst;
      cnt_q       <= '0;
      ibits_q     <= '0;
      qbits_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ibits_q <= ibits_d;
      qbits_q <= qbits_d;
      err_q   <= err_d;
      // A new word may load in the same cycle the previous one is taken.
      if (load) begin
        out_data_q  <= {ibits_q, qbits_d};
        out_valid_q <= 1'b1;
        out_last_q  <= s00_axis_tlast;
      end else if (m00_axis_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign m00_axis_tdata  = out_data_q;
  assign m00_axis_tvalid = out_valid_q;
  assign m00_axis_tlast  = out_last_q;
  assign frame_error     = err_q;

`ifdef SYMBOL_ERROR_COUNT_EN
  // Data slot offends when more than 0x0800 away from the nearer of +/-0x5A12.
  function automatic logic data_off(input logic [15:0] x);
    logic signed [17:0] d;
    d = $signed({{2{x[15]}}, x}) - (x[15] ? -18'sd23058 : 18'sd23058);
    return (d > 18'sd2048) || (d < -18'sd2048);
  endfunction

  logic        i_off, q_off;
  logic [1:0]  inc;
  logic [16:0] sum;
  logic [15:0] ecnt_q, ecnt_d;

  always_comb begin
    i_off  = (state_q == StLast) ? (s00_axis_tdata[31:16] != 16'h0000)
                                 : data_off(s00_axis_tdata[31:16]);
    q_off  = (state_q == StFirst) ? (s00_axis_tdata[15:0] != 16'h0000)
                                  : data_off(s00_axis_tdata[15:0]);
    inc    = {1'b0, i_off} + {1'b0, q_off};
    sum    = {1'b0, ecnt_q} + {15'd0, inc};
    ecnt_d = ecnt_q;
    if (beat) begin
      ecnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign error_count = ecnt_q;
`endif

endmodule

// File: tb/tb_oqpsk_symbol_slicer.sv
// Self-checking bench for oqpsk_symbol_slicer: vector table, hand sequences and a randomized
// run scored against a frame-level reference model.
module tb_oqpsk_symbol_slicer;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        frame_error;
`ifdef SYMBOL_ERROR_COUNT_EN
  logic [15:0] error_count;
`endif

  oqpsk_symbol_slicer #(
    .C_M00_AXIS_TDATA_WIDTH(16),
    .C_S00_AXIS_TDATA_WIDTH(32)
  ) dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(areset),
    .s00_axis_tdata (s_tdata),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tready(s_tready),
    .s00_axis_tlast (s_tlast),
    .m00_axis_tdata (m_tdata),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tready(m_tready),
    .m00_axis_tlast (m_tlast),
`ifdef SYMBOL_ERROR_COUNT_EN
    .error_count    (error_count),
`endif
    .frame_error    (frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  logic [15:0] last_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Sink: ready follows sink_ready, or toggles randomly.
  logic rand_sink  = 1'b0;
  logic sink_ready = 1'b1;
  always begin
    @(negedge clk);
    #1;
    m_tready = rand_sink ? ($urandom_range(0, 3) != 0) : sink_ready;
  end

  // Reference model: collect accepted beats per frame; a frame is W+1 beats.
  typedef struct {logic [15:0] data; logic last;} out_t;
  logic [15:0] bi[$];
  logic [15:0] bq[$];
  out_t        exp_q[$];
  out_t        e;
  logic [15:0] w;
  logic        exp_err = 1'b0;
  logic        prev_hold = 1'b0;
  logic [16:0] prev_word;

  always begin
    @(negedge clk);
    #3;
    if (areset) begin
      bi.delete(); bq.delete(); exp_q.delete();
      exp_err   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("frame_error", frame_error, exp_err);
      exp_err = 1'b0;
      if (prev_hold) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_word", {m_tlast, m_tdata}, prev_word);
      end
      if (m_tvalid && m_tready) begin
        out_count++;
        last_out = m_tdata;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual %h required none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", m_tdata, e.data);
          chk("word_last", m_tlast, e.last);
        end
      end
      prev_hold = m_tvalid && !m_tready;
      prev_word = {m_tlast, m_tdata};
      if (s_tvalid && s_tready) begin
        bi.push_back(s_tdata[31:16]);
        bq.push_back(s_tdata[15:0]);
        if (bi.size() == W + 1) begin
          for (int k = 0; k < W; k++) begin
            w[W+k] = ~bi[k][15];
            w[k]   = ~bq[k+1][15];
          end
          e.data = w;
          e.last = s_tlast;
          exp_q.push_back(e);
          bi.delete(); bq.delete();
        end else if (s_tlast) begin
          exp_err = 1'b1;
          bi.delete(); bq.delete();
        end
      end
    end
  end

  function automatic logic [15:0] enc(input logic b);
    return b ? 16'h5A12 : 16'hA5EE;
  endfunction

  function automatic logic [31:0] frame_beat(input logic [15:0] word, input int k);
    logic [15:0] i, q;
    i = (k < W) ? enc(word[W+k]) : 16'h0000;
    q = (k > 0) ? enc(word[k-1]) : 16'h0000;
    return {i, q};
  endfunction

  function automatic logic [15:0] rnd_sample();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h5A12;
      2:       return 16'hA5EE;
      default: return 16'($urandom);
    endcase
  endfunction

  // Called on a negedge; returns on the negedge after the beat is accepted.
  task automatic send_beat(input logic [15:0] i, input logic [15:0] q, input logic last);
    int n;
    n = 0;
    s_tdata  = {i, q};
    s_tlast  = last;
    s_tvalid = 1'b1;
    #3;
    while (!s_tready && n < 1000) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!s_tready) begin
      checks++; errors++;
      $display("FAIL beat_timeout actual stalled required accepted");
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] word, input int abort_at, input logic last_flag);
    logic [31:0] b;
    for (int k = 0; k <= W; k++) begin
      b = frame_beat(word, k);
      if (k == abort_at) begin
        send_beat(b[31:16], b[15:0], 1'b1);
        return;
      end
      send_beat(b[31:16], b[15:0], (k == W) ? last_flag : 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual pending %0d required 0", exp_q.size());
    end
  endtask

  typedef struct {
    logic [15:0] word;
    int          abort_at;
    logic        last_flag;
    logic [15:0] exp_word;
    logic        exp_last;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[9];
  int          pre;
  int          len;
  logic        lst_final;
  logic [31:0] b;

  initial begin
    vecs[0] = '{16'hA5C3, -1, 1'b1, 16'hA5C3, 1'b1, 1'b0};
    vecs[1] = '{16'h0000, -1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, -1, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h1234,  4, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, -1, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[5] = '{16'h00FF, -1, 1'b0, 16'h00FF, 1'b0, 1'b0};
    vecs[6] = '{16'h5555,  0, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{16'h3C3C,  7, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{16'h8001, -1, 1'b1, 16'h8001, 1'b1, 1'b0};

    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_s_tready", s_tready, 1);
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);

    // Table: one frame per entry, word due exactly one cycle after the final beat.
    foreach (vecs[v]) begin
      send_frame(vecs[v].word, vecs[v].abort_at, vecs[v].last_flag);
      s_tvalid = 1'b0;
      #3;
      if (vecs[v].exp_err) begin
        chk("vec_err_pulse", frame_error, 1);
        chk("vec_no_word", m_tvalid, 0);
      end else begin
        chk("vec_valid", m_tvalid, 1);
        chk("vec_data", m_tdata, vecs[v].exp_word);
        chk("vec_last", m_tlast, vecs[v].exp_last);
      end
      @(negedge clk);
      #3;
      chk("vec_valid_1cyc", m_tvalid, 0);
      chk("vec_err_1cyc", frame_error, 0);
      @(negedge clk);
    end

    // Back-to-back words with the sink stalled on the first one.
    pre = out_count;
    sink_ready = 1'b0;
    send_frame(16'h0000, -1, 1'b1);
    s_tvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("stall_s_tready", s_tready, 0);
      chk("stall_m_tvalid", m_tvalid, 1);
      chk("stall_m_tdata", m_tdata, 16'h0000);
      @(negedge clk);
    end
    sink_ready = 1'b1;
    send_frame(16'hFFFF, -1, 1'b1);
    s_tvalid = 1'b0;
    drain();
    chk("b2b_count", out_count - pre, 2);
    chk("b2b_last_word", last_out, 16'hFFFF);

    // Reset in the middle of a frame: partial bits are lost.
    for (int k = 0; k < 5; k++) begin
      b = frame_beat(16'hAAAA, k);
      send_beat(b[31:16], b[15:0], 1'b0);
    end
    pre = out_count;
    b = frame_beat(16'hAAAA, 5);
    areset  = 1'b1;
    s_tdata = b;
    @(negedge clk);
    #3;
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_m_tdata", m_tdata, 0);
    chk("midrst_frame_error", frame_error, 0);
    chk("midrst_s_tready", s_tready, 1);
    @(negedge clk);
    areset   = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    send_frame(16'h00FF, -1, 1'b1);
    s_tvalid = 1'b0;
    drain();
    chk("midrst_count", out_count - pre, 1);
    chk("midrst_word", last_out, 16'h00FF);

`ifdef SYMBOL_ERROR_COUNT_EN
    chk("ecount_zero", error_count, 0);
    for (int k = 0; k <= W; k++) begin
      b = frame_beat(16'h5A5A, k);
      if (k == 0) b[15:0] = 16'h0100;
      if (k == 3) b[31:16] = 16'h3000;
      send_beat(b[31:16], b[15:0], k == W);
    end
    s_tvalid = 1'b0;
    #3;
    chk("ecount_word", m_tdata, 16'h5A5A);
    chk("ecount_value", error_count, 2);
    @(negedge clk);
    drain();
`endif

    // Randomized frames, aborts, gaps and sink back-pressure.
    rand_sink = 1'b1;
    for (int f = 0; f < 250; f++) begin
      len       = ($urandom_range(0, 5) == 0) ? $urandom_range(1, W) : W + 1;
      lst_final = ($urandom_range(0, 4) != 0);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_tvalid = 1'b0;
          @(negedge clk);
        end
        send_beat(rnd_sample(), rnd_sample(),
                  (k == len - 1) ? ((len == W + 1) ? lst_final : 1'b1) : 1'b0);
      end
    end
    s_tvalid   = 1'b0;
    rand_sink  = 1'b0;
    sink_ready = 1'b1;
    @(negedge clk);
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oqpsk_symbol_slicer.md
Name: oqpsk_symbol_slicer

Overview:
- Receive-side counterpart of the OQPSK modulator's output formatter.
- Accepts the 32-bit I/Q sample stream: I in [31:16], Q in [15:0], signed Q1.15, nominally ±0x5A12/0xA5EE, 0 on offset slots.
- Slices the sign of each sample, strips the half-symbol I/Q offset, reassembles the bits into C_M00_AXIS_TDATA_WIDTH-bit words and emits them on an AXI-Stream master.
- Sits between the channel/loopback path and the packet sink.

Parameters:
- C_M00_AXIS_TDATA_WIDTH, 16, width of the output word. Must be even and ≥4. W = C_M00_AXIS_TDATA_WIDTH/2 bits per branch.
- C_S00_AXIS_TDATA_WIDTH, 32, width of the input sample beat. Fixed at 32.

Ports:
- s00_axis_aclk  in  1  single clock for both streams.
- s00_axis_areset  in  1  synchronous, active-high reset.
- s00_axis_tdata  in  32  [31:16] I sample, [15:0] Q sample.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tready  out  1  input beat accepted when tvalid&tready.
- s00_axis_tlast  in  1  marks the final beat of a frame.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  reassembled word: I bits in [2W-1:W], Q bits in [W-1:0].
- m00_axis_tvalid  out  1  output word valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tlast  out  1  copy of s00_axis_tlast from the word's final beat.
- frame_error  out  1  one-cycle pulse on an aborted frame.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values: all outputs 0, except s00_axis_tready = 1. State = FIRST, beat counter = 0, shift registers = 0.
- Frame: W+1 accepted beats.
  - Beat 0: I carries bit 0; Q is the offset slot and is ignored.
  - Beat k (1..W-1): I carries bit k; Q carries bit k-1.
  - Beat W: I is the offset slot and is ignored; Q carries bit W-1.
  - Bit order is LSB first.
- Slicing: bit = ~sample[15]. A zero sample on a data slot slices to 1.
- State machine, advancing only on an accepted beat:
  - FIRST: capture I into ibits[0] → MIDDLE, or → LAST if W=1 (not permitted).
  - MIDDLE: capture I into ibits[cnt] and Q into qbits[cnt-1]; when cnt == W-1 → LAST.
  - LAST: capture Q into qbits[W-1]; load the output register; → FIRST.
- Output register: loaded from LAST with {ibits, sliced Q}. m00_axis_tvalid rises on the next cycle, so latency is 1 clock from the final beat handshake to tvalid.
- Output hold: word and tvalid hold until m00_axis_tready is high. Clear tvalid on the handshake unless a new word loads in the same cycle.
- Input back-pressure: s00_axis_tready = ~(m00_axis_tvalid & ~m00_axis_tready). Input stalls whenever an undelivered word is held. A word loading in the same cycle as the old word's handshake is legal.
- Premature tlast (tlast on an accepted beat in FIRST or MIDDLE):
  - discard partial bits, → FIRST, pulse frame_error;
  - no output word.
- Missing tlast: tlast low on the LAST beat is legal (continuous streaming); m00_axis_tlast = 0 for that word.
- Stalled input: tvalid low holds all state; there is no timeout.
- Mid-frame reset: the reset value applies on the next edge and the partial frame is lost. A held output word is dropped.

Optional Feature:
- Macro: SYMBOL_ERROR_COUNT_EN.
- Defined:
  - Adds output error_count (16 bits, reset 0, saturating at 0xFFFF).
  - Increments by 1 per offending sample per accepted beat, i.e. 0, 1 or 2 per beat.
  - Offence on a data slot: |sample − nearest nominal| > 0x0800.
  - Offence on an offset slot: sample ≠ 0.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Single word: beats 0..8 encode I=0xA5, Q=0xC3 (beat 0: I=0x5A12, Q=0; beat 8: I=0, Q=0x5A12, tlast=1) with m00_axis_tready=1 → m00_axis_tdata=0xA5C3 and tlast=1 one cycle after beat 8, valid for 1 cycle.
- Back-to-back words 0x0000 then 0xFFFF with m00_axis_tready low for 5 cycles after the first word → s00_axis_tready low during the hold. Both words delivered in order, nothing lost.
- tlast asserted on beat 4 → frame_error pulses for 1 cycle and there is no output. The next full frame encoding 0x1234 → output 0x1234.
- Reset asserted at beat 5, then a full frame encoding 0x00FF → outputs 0 during reset; the only word out is 0x00FF.
- SYMBOL_ERROR_COUNT_EN defined, one frame with Q=0x0100 on beat 0 and I=0x3000 on beat 3 → error_count=2 and output word unaffected; 0x3000 slices to 1.
